// File: rtl/ed25519_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ed25519_io_ctrl
// Description : Stream-side front end of the ed25519 point-multiply core.
//               Collects 12 x 64-bit input beats (scalar, Px, Py, each
//               MSB-first) into operand registers, pulses the core start,
//               captures the 512-bit result {Rx, Ry} on core done and
//               replays it as 8 x 64-bit output beats, MSB-first.
// Ports       :
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_in_valid / o_in_ready   input beat handshake, i_in_data payload
//   o_out_valid / i_out_ready output beat handshake, o_out_data payload
//   o_scalar, o_px, o_py      operands presented to the core
//   o_core_start              one-cycle launch pulse
//   i_core_done, i_rx, i_ry   single-cycle result strobe and result
// Revision    : 1.0  initial release
// ============================================================================
module ed25519_io_ctrl #(
    parameter int DATA_W    = 64,
    parameter int PATN_W    = 256,
    parameter int IN_BEATS  = 3 * PATN_W / DATA_W,
    parameter int OUT_BEATS = 2 * PATN_W / DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [PATN_W-1:0] o_scalar,
    output logic [PATN_W-1:0] o_px,
    output logic [PATN_W-1:0] o_py,
    output logic              o_core_start,
    input  logic              i_core_done,
    input  logic [PATN_W-1:0] i_rx,
    input  logic [PATN_W-1:0] i_ry
);

    localparam int c_max_beats = (IN_BEATS > OUT_BEATS) ? IN_BEATS : OUT_BEATS;
    localparam int c_cnt_w     = $clog2(c_max_beats);
    localparam int c_opnd_w    = 3 * PATN_W;
    localparam int c_res_w     = 2 * PATN_W;

    localparam logic [1:0] c_st_recv  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_busy  = 2'd2;
    localparam logic [1:0] c_st_send  = 2'd3;

    localparam logic [c_cnt_w-1:0] c_in_last  = c_cnt_w'(IN_BEATS - 1);
    localparam logic [c_cnt_w-1:0] c_out_last = c_cnt_w'(OUT_BEATS - 1);

    logic [1:0]          r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_opnd_w-1:0] r_opnd;      // {scalar, Px, Py}
    logic [c_res_w-1:0]  r_sr;        // {Rx, Ry}, shifted left per output beat
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_core_start;

    logic w_in_hs;
    logic w_out_hs;

    assign w_in_hs  = i_in_valid & r_in_ready;
    assign w_out_hs = r_out_valid & i_out_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= c_st_recv;
            r_cnt        <= '0;
            r_opnd       <= '0;
            r_sr         <= '0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_core_start <= 1'b0;
        end else begin
            case (r_state)
                c_st_recv: begin
                    if (w_in_hs) begin
                        // Each beat lands directly in its own slice, so
                        // the operands of the previous job stay intact
                        // except for the slice just overwritten.
                        for (int b = 0; b < IN_BEATS; b++) begin
                            if (r_cnt == c_cnt_w'(b)) begin
                                r_opnd[(c_opnd_w-1)-b*DATA_W -: DATA_W] <= i_in_data;
                            end
                        end
                        if (r_cnt == c_in_last) begin
                            r_cnt        <= '0;
                            r_state      <= c_st_start;
                            r_in_ready   <= 1'b0;
                            r_core_start <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                c_st_start: begin
                    r_core_start <= 1'b0;
                    r_state      <= c_st_busy;
                end

                c_st_busy: begin
                    if (i_core_done) begin
                        r_sr        <= {i_rx, i_ry};
                        r_out_valid <= 1'b1;
                        r_state     <= c_st_send;
                    end
                end

                c_st_send: begin
                    if (w_out_hs) begin
                        r_sr <= {r_sr[c_res_w-DATA_W-1:0], {DATA_W{1'b0}}};
                        if (r_cnt == c_out_last) begin
                            // Ready rises on the same edge as the final
                            // output beat so the next job can stream in
                            // immediately.
                            r_cnt       <= '0;
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_state     <= c_st_recv;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state      <= c_st_recv;
                    r_cnt        <= '0;
                    r_in_ready   <= 1'b1;
                    r_out_valid  <= 1'b0;
                    r_core_start <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out_valid ? r_sr[c_res_w-1 -: DATA_W] : '0;
    assign o_core_start = r_core_start;
    assign o_scalar     = r_opnd[c_opnd_w-1 -: PATN_W];
    assign o_px         = r_opnd[2*PATN_W-1 -: PATN_W];
    assign o_py         = r_opnd[PATN_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_ed25519_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ed25519_io_ctrl
// Description : Directed self-checking bench for ed25519_io_ctrl with a
//               simple core model that answers 20 cycles after start.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ed25519_io_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic [255:0] scalar, px, py;
    logic         core_start;
    logic         core_done;
    logic         model_done;
    logic         spur_done;
    logic [255:0] rx_v, ry_v;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign core_done = model_done | spur_done;

    ed25519_io_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_data    (in_data),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data),
        .o_scalar     (scalar),
        .o_px         (px),
        .o_py         (py),
        .o_core_start (core_start),
        .i_core_done  (core_done),
        .i_rx         (rx_v),
        .i_ry         (ry_v)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Core model: done pulse 20 cycles after the start pulse is seen.
    initial begin
        model_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (core_start === 1'b1) begin
                for (int i = 0; i < 19; i++) begin
                    @(posedge clk); #1;
                    check("busy_rdy", 256'(in_ready), 256'(0));
                end
                model_done = 1'b1;
                @(posedge clk); #1;
                model_done = 1'b0;
                check("done_lat", 256'(out_valid), 256'(1));
            end
        end
    end

    // Ready must stay low while launching / sending; data is zero when idle.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rst_n === 1'b1) begin
                if (core_start || out_valid) check("phase_rdy", 256'(in_ready), 256'(0));
                if (!out_valid) check("idle_data", 256'(out_data), 256'(0));
            end
        end
    end

    task automatic send_job(input logic [767:0] job, input int nbeats, input int stall, input int spur_beat);
        int  b = 0;
        int  guard = 0;
        logic hs;
        while (b < nbeats && guard < 1000) begin
            in_valid  = ($urandom_range(99) >= stall);
            in_data   = job[767-64*b -: 64];
            hs        = in_valid && in_ready;
            spur_done = (b == spur_beat);
            @(posedge clk); #1;
            spur_done = 1'b0;
            if (hs) b++;
            guard++;
        end
        in_valid = 1'b0;
        check("send_cnt", 256'(b), 256'(nbeats));
    endtask

    task automatic recv_job(input logic [511:0] exp, input int stall, input int hold_beat,
                            input int hold_cyc, input int spur_beat);
        int   b = 0;
        int   guard = 0;
        logic held = 1'b0;
        logic hs;
        while (b < 8 && guard < 2000) begin
            if (out_valid) begin
                check("out_data", 256'(out_data), 256'(exp[511-64*b -: 64]));
                if (b == hold_beat && !held) begin
                    held      = 1'b1;
                    out_ready = 1'b0;
                    repeat (hold_cyc) @(posedge clk);
                    #1;
                    check("hold_valid", 256'(out_valid), 256'(1));
                    check("hold_data", 256'(out_data), 256'(exp[511-64*b -: 64]));
                    check("hold_rdy", 256'(in_ready), 256'(0));
                end
            end
            out_ready = ($urandom_range(99) >= stall);
            spur_done = (b == spur_beat) && out_valid;
            hs        = out_valid && out_ready;
            @(posedge clk); #1;
            spur_done = 1'b0;
            if (hs) b++;
            guard++;
        end
        out_ready = 1'b0;
        check("recv_cnt", 256'(b), 256'(8));
        check("end_valid", 256'(out_valid), 256'(0));
        check("end_ready", 256'(in_ready), 256'(1));
    endtask

    task automatic run_job(input logic [767:0] job, input logic [255:0] rx, input logic [255:0] ry,
                           input int stall, input int spur_in, input int spur_out,
                           input int hold_beat, input int hold_cyc);
        rx_v = rx;
        ry_v = ry;
        send_job(job, 12, stall, spur_in);
        check("start_hi", 256'(core_start), 256'(1));
        check("start_rdy", 256'(in_ready), 256'(0));
        @(posedge clk); #1;
        check("start_lo", 256'(core_start), 256'(0));
        check("scalar", scalar, job[767:512]);
        check("px", px, job[511:256]);
        check("py", py, job[255:0]);
        recv_job({rx, ry}, stall, hold_beat, hold_cyc, spur_out);
    endtask

    logic [767:0] job;
    logic [255:0] rx, ry;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        spur_done = 1'b0; rx_v = '0; ry_v = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 256'(in_ready), 256'(1));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_out_data", 256'(out_data), 256'(0));
        check("rst_start", 256'(core_start), 256'(0));
        check("rst_scalar", scalar, 256'(0));
        check("rst_px", px, 256'(0));
        check("rst_py", py, 256'(0));
        rst_n = 1'b1;

        // Job 1: beat k carries k+1, no stalls, fixed result pattern.
        for (int k = 0; k < 12; k++) job[767-64*k -: 64] = 64'(k + 1);
        run_job(job, {4{64'h1111111111111111}}, {4{64'h2222222222222222}}, 0, -1, -1, -1, 0);

        // Job 2: random data with 50% stalls and spurious done pulses.
        for (int k = 0; k < 12; k++) job[767-64*k -: 64] = {$urandom, $urandom};
        for (int k = 0; k < 8; k++) begin
            rx[255-32*k -: 32] = $urandom;
            ry[255-32*k -: 32] = $urandom;
        end
        run_job(job, rx, ry, 50, 5, 2, -1, 0);

        // Reset after 7 beats, then a full job with a long output stall.
        send_job(job, 7, 0, -1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_ready", 256'(in_ready), 256'(1));
        check("mid_rst_scalar", scalar, 256'(0));
        check("mid_rst_start", 256'(core_start), 256'(0));
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) job[767-64*k -: 64] = {$urandom, $urandom};
        run_job(job, ~rx, ~ry, 0, -1, -1, 3, 50);

        // Back-to-back random jobs with stalls on both sides.
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 12; k++) job[767-64*k -: 64] = {$urandom, $urandom};
            for (int k = 0; k < 8; k++) begin
                rx[255-32*k -: 32] = $urandom;
                ry[255-32*k -: 32] = $urandom;
            end
            run_job(job, rx, ry, 50, -1, -1, -1, 0);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ed25519_io_ctrl.md
Name: ed25519_io_ctrl

Overview:
- Stream-side front end of the ed25519 core.
- Deserializes 12 × 64-bit input beats (scalar, Px, Py) into 256-bit operand registers and launches the point-multiply core.
- Captures the core's 256-bit result (Rx, Ry) and serializes it as 8 × 64-bit output beats.
- Provides the valid/ready stream endpoints that the system bench drives and consumes.

Parameters:
- DATA_W, 64, stream beat width in bits
- PATN_W, 256, operand width in bits
- IN_BEATS, 3*PATN_W/DATA_W (12), input beats per job
- OUT_BEATS, 2*PATN_W/DATA_W (8), output beats per job

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_in_valid  in  1  input beat valid
- o_in_ready  out  1  input beat ready
- i_in_data  in  DATA_W  input beat
- o_out_valid  out  1  output beat valid
- i_out_ready  in  1  output beat ready
- o_out_data  out  DATA_W  output beat
- o_scalar  out  PATN_W  scalar to core
- o_px  out  PATN_W  input point x to core
- o_py  out  PATN_W  input point y to core
- o_core_start  out  1  one-cycle launch pulse to core
- i_core_done  in  1  core result valid, single-cycle pulse
- i_rx  in  PATN_W  result x from core
- i_ry  in  PATN_W  result y from core

Behaviour:
- Clock and reset:
  - Single clock i_clk.
  - Reset is synchronous, active-low (i_rst_n sampled at the i_clk rising edge).
  - Reset values: state=RECV, beat counter=0, o_in_ready=1, o_out_valid=0, o_out_data=0, o_core_start=0, o_scalar/o_px/o_py=0, output shift register=0.
- Handshakes:
  - An input beat transfers on a rising edge where i_in_valid && o_in_ready.
  - An output beat transfers on a rising edge where o_out_valid && i_out_ready.
  - Peak throughput is 1 beat/cycle. Stalls on either side are legal at any beat.
- Input order is MSB-first across {scalar, Px, Py}:
  - beat 0 = scalar[255:192], beat 3 = scalar[63:0]
  - beat 4 = Px[255:192], beat 8 = Py[255:192]
  - beat 11 = Py[63:0]
- Output order is MSB-first across {Rx, Ry}:
  - beat 0 = Rx[255:192], beat 7 = Ry[63:0]
- FSM states:
  - RECV:
    - o_in_ready=1. Each accepted beat is stored into its operand slice and the counter increments.
    - The 12th accepted beat moves the FSM to START and clears the counter.
    - i_in_valid with no handshake leaves the state unchanged.
  - START:
    - Lasts exactly 1 cycle. o_core_start=1, o_in_ready=0, then go to BUSY.
    - Operand registers are stable from START until the next job's first accepted beat.
  - BUSY:
    - o_in_ready=0. Wait for i_core_done.
    - On done, load {i_rx, i_ry} into the 512-bit shift register and go to SEND.
  - SEND:
    - o_out_valid=1 and o_out_data = shift register bits [511:448].
    - Each output handshake shifts left by DATA_W and increments the counter.
    - The 8th handshake clears o_out_valid at the next edge, clears the counter and returns to RECV.
    - o_in_ready is 0 throughout SEND.
- i_core_done is ignored in RECV, START and SEND (no capture, no state change).
- o_out_data is forced to 0 whenever o_out_valid=0.
- Latency:
  - Last input handshake at edge N → o_core_start high in cycle N..N+1.
  - i_core_done sampled at edge M → o_out_valid=1 from edge M.
  - Last output handshake at edge K → o_in_ready=1 from edge K (next job may start next edge).
- Back-to-back jobs need no idle cycles beyond START/BUSY.
- Reset mid-operation (any state) discards the partial job and all outputs take their reset values at that edge. A core done arriving afterwards is ignored.
- Holding i_out_ready=0 indefinitely in SEND holds o_out_data stable and o_in_ready=0. No data is lost or duplicated.

Test Plan:
- Continuous valid, no stall: inputs 0x0000...0001..0x...000C (beat k = k+1) → o_scalar = {1,2,3,4}, o_px = {5..8}, o_py = {9..12} as 64-bit words; o_core_start high exactly 1 cycle, 1 cycle after the 12th beat.
- Core model returns done 20 cycles after start with Rx = 256'h11..11, Ry = 256'h22..22 → 8 output beats: four 64'h1111111111111111 then four 64'h2222222222222222, o_out_valid high from the done edge.
- Random in_valid/out_ready (50%) over 20 jobs using the ed25519 golden pattern files → operands and serialized output bit-exact with golden; no beat dropped or repeated; o_in_ready=0 throughout START/BUSY/SEND.
- Spurious i_core_done asserted while in RECV at beat 5 and during SEND → no state change, counter and output sequence unaffected.
- Assert i_rst_n=0 for 1 cycle after 7 input beats, then send a full job → first post-reset beat lands in scalar[255:192]; result correct.
- Hold i_out_ready=0 for 50 cycles at output beat 3 → o_out_data stable at beat 3 value, o_out_valid=1; resuming delivers beats 3..7 exactly once, then o_in_ready=1.
